// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3)
      F3_H, F3_HU: return addr[0];
      F3_W:        return addr != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic is_unsupported(input logic [2:0] funct3);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication, load extraction, legality check.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            illegal
);

  logic [7:0]  lb;
  logic [15:0] lh;
  logic        sext;

  always_comb begin
    lb        = rdata[{addr, 3'b000} +: 8];
    lh        = rdata[{addr[1], 4'b0000} +: 16];
    sext      = ~funct3[2];
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    // funct3[1:0] selects size; funct3[2] selects zero-extension on loads
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr;
        wdata     = {(XLEN/8){store_data[7:0]}};
        load_data = {{(XLEN-8){lb[7] & sext}}, lb};
      end
      2'b01: begin
        be        = 4'b0011 << addr;
        wdata     = {(XLEN/16){store_data[15:0]}};
        load_data = {{(XLEN-16){lh[15] & sext}}, lh};
      end
      default: ;
    endcase
    illegal = is_misaligned(funct3, addr) || is_unsupported(funct3);
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32 MEM stage: req/ready data-memory sequencer plus the MEM/WB pipeline register.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   ResultM,
  input  logic [XLEN-1:0]   ADDRTargetM,
  input  logic [4:0]        RdM,
  input  logic [XLEN-1:0]   StoreDataM,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic              RegWriteM,
  input  logic [2:0]        Funct3M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              StallM,
  output logic              MisalignM,
  output logic [XLEN-1:0]   ResultW,
  output logic [XLEN-1:0]   ADDRTargetW,
  output logic [4:0]        RdW,
  output logic              RegWriteW
);

  mem_state_t      state;
  logic            access;
  logic            illegal;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] load_data;

  assign access = MemReadM | MemWriteM;

  // M-stage inputs are frozen by StallM, so they are still valid at completion
  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (Funct3M),
    .addr       (ResultM[1:0]),
    .store_data (StoreDataM),
    .rdata      (dmem_rdata),
    .be         (be),
    .wdata      (wdata),
    .load_data  (load_data),
    .illegal    (illegal)
  );

  assign StallM = (state == BUSY) || (state == IDLE && access && !illegal);

  always_ff @(negedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      MisalignM   <= 1'b0;
      ResultW     <= '0;
      ADDRTargetW <= '0;
      RdW         <= '0;
      RegWriteW   <= 1'b0;
    end else begin
      MisalignM <= 1'b0;
      case (state)
        IDLE: begin
          if (access && illegal) begin
            MisalignM <= 1'b1;
            RegWriteW <= 1'b0;
          end else if (access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWriteM;
            dmem_addr  <= {ResultM[ADDR_W-1:2], 2'b00};
            dmem_be    <= be;
            dmem_wdata <= wdata;
            RegWriteW  <= 1'b0;
            state      <= BUSY;
          end else begin
            ResultW     <= ResultM;
            ADDRTargetW <= ADDRTargetM;
            RdW         <= RdM;
            RegWriteW   <= RegWriteM;
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            state    <= RESP;
            if (dmem_we) begin
              RegWriteW <= 1'b0;
            end else begin
              ResultW   <= load_data;
              RdW       <= RdM;
              RegWriteW <= RegWriteM;
            end
          end
        end
        RESP: begin
          // the same instruction is still in M this cycle; bubble WB
          RegWriteW <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed vector bench for mem_stage_lsu with a reset-in-BUSY sequence.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ResultM, ADDRTargetM, StoreDataM;
  logic [4:0]  RdM;
  logic        MemReadM, MemWriteM, RegWriteM;
  logic [2:0]  Funct3M;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        StallM, MisalignM, RegWriteW;
  logic [31:0] ResultW, ADDRTargetW;
  logic [4:0]  RdW;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .reset(reset),
    .ResultM(ResultM), .ADDRTargetM(ADDRTargetM), .RdM(RdM), .StoreDataM(StoreDataM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .Funct3M(Funct3M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .MisalignM(MisalignM), .ResultW(ResultW), .ADDRTargetW(ADDRTargetW),
    .RdW(RdW), .RegWriteW(RegWriteW)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        rd, wr, rw;
    logic [2:0]  f3;
    logic [4:0]  rdn;
    logic [31:0] addr, sd, rdata;
    int          waits;
    int          exp_stall;
    logic        exp_mis, exp_rw, exp_we, chk_res;
    logic [31:0] exp_res;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  function automatic vec_t mk(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [4:0] rdn, input logic rw, input logic [31:0] addr,
                              input logic [31:0] sd, input logic [31:0] rdata, input int waits,
                              input int exp_stall, input logic exp_mis, input logic exp_rw,
                              input logic exp_we, input logic chk_res, input logic [31:0] exp_res,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    vec_t t;
    t.name = name; t.rd = rd; t.wr = wr; t.f3 = f3; t.rdn = rdn; t.rw = rw;
    t.addr = addr; t.sd = sd; t.rdata = rdata; t.waits = waits; t.exp_stall = exp_stall;
    t.exp_mis = exp_mis; t.exp_rw = exp_rw; t.exp_we = exp_we; t.chk_res = chk_res;
    t.exp_res = exp_res; t.exp_be = exp_be; t.exp_wdata = exp_wdata;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    MemReadM    = t.rd;
    MemWriteM   = t.wr;
    Funct3M     = t.f3;
    RdM         = t.rdn;
    RegWriteM   = t.rw;
    ResultM     = t.addr;
    StoreDataM  = t.sd;
    ADDRTargetM = t.addr ^ 32'hCAFE_0000;
  endtask

  vec_t nop;

  task automatic run_vec(input vec_t t);
    int stalls, busy;
    logic first, stable;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;
    stalls = 0; busy = 0; first = 1'b1; stable = 1'b1;
    c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
    @(posedge clk);
    drive(t);
    dmem_ready = 1'b0;
    forever begin
      #1;
      if (!StallM) break;
      stalls++;
      if (dmem_req) begin
        if (first) begin
          c_we = dmem_we; c_addr = dmem_addr; c_be = dmem_be; c_wdata = dmem_wdata; first = 1'b0;
        end else if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {c_we, c_addr, c_be, c_wdata}) begin
          stable = 1'b0;
        end
        if (busy == t.waits) begin
          dmem_ready = 1'b1;
          dmem_rdata = t.rdata;
        end
        busy++;
      end
      if (stalls > 40) break;
      @(posedge clk);
      dmem_ready = 1'b0;
      dmem_rdata = 32'h0BAD_F00D;
    end
    chk({t.name, " stall cycles"}, stalls, t.exp_stall);
    if (t.exp_stall == 0) begin
      chk({t.name, " no request"}, {31'd0, dmem_req}, 32'd0);
      @(posedge clk);
      drive(nop);
      #1;
    end
    chk({t.name, " RegWriteW"}, {31'd0, RegWriteW}, {31'd0, t.exp_rw});
    chk({t.name, " MisalignM"}, {31'd0, MisalignM}, {31'd0, t.exp_mis});
    if (t.chk_res) chk({t.name, " ResultW"}, ResultW, t.exp_res);
    if (t.exp_rw) chk({t.name, " RdW"}, {27'd0, RdW}, {27'd0, t.rdn});
    if (!t.rd && !t.wr) chk({t.name, " ADDRTargetW"}, ADDRTargetW, t.addr ^ 32'hCAFE_0000);
    if (t.exp_stall > 0) begin
      chk({t.name, " dmem_we"}, {31'd0, c_we}, {31'd0, t.exp_we});
      chk({t.name, " dmem_addr"}, c_addr, {t.addr[31:2], 2'b00});
      chk({t.name, " dmem stable"}, {31'd0, stable}, 32'd1);
      if (t.exp_we) begin
        chk({t.name, " dmem_be"}, {28'd0, c_be}, {28'd0, t.exp_be});
        chk({t.name, " dmem_wdata"}, c_wdata, t.exp_wdata);
      end
    end
    // one-cycle pulses: writeback enable and misalign must be gone next cycle
    @(posedge clk);
    drive(nop);
    #1;
    chk({t.name, " RegWriteW pulse"}, {31'd0, RegWriteW}, 32'd0);
    chk({t.name, " MisalignM pulse"}, {31'd0, MisalignM}, 32'd0);
  endtask

  vec_t v[$];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    nop = mk("nop", 0, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
    //        name       rd wr f3      rd  rw addr          sd            rdata         w  st mis rw we cr exp_res       be       wdata
    v.push_back(mk("alu",     0, 0, 3'b000, 5,  1, 32'h0000_1234, 32'h0,        32'h0,        0, 0, 0, 1, 0, 1, 32'h0000_1234, 4'h0,    32'h0));
    v.push_back(mk("lb_s",    1, 0, 3'b000, 10, 1, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 0, 2, 0, 1, 0, 1, 32'hFFFF_FF80, 4'h0,    32'h0));
    v.push_back(mk("lhu_w3",  1, 0, 3'b101, 11, 1, 32'h0000_0202, 32'h0,        32'hBEEF_0000, 3, 5, 0, 1, 0, 1, 32'h0000_BEEF, 4'h0,    32'h0));
    v.push_back(mk("sb",      0, 1, 3'b000, 2,  1, 32'h0000_0301, 32'h0000_00AB, 32'h0,        0, 2, 0, 0, 1, 0, 32'h0,        4'b0010, 32'hABAB_ABAB));
    v.push_back(mk("lw_mis",  1, 0, 3'b010, 12, 1, 32'h0000_0102, 32'h0,        32'h0,        0, 0, 1, 0, 0, 0, 32'h0,        4'h0,    32'h0));
    v.push_back(mk("lh_s",    1, 0, 3'b001, 13, 1, 32'h0000_0206, 32'h0,        32'h8001_1234, 0, 2, 0, 1, 0, 1, 32'hFFFF_8001, 4'h0,    32'h0));
    v.push_back(mk("lbu",     1, 0, 3'b100, 14, 1, 32'h0000_0102, 32'h0,        32'h12F0_3456, 0, 2, 0, 1, 0, 1, 32'h0000_00F0, 4'h0,    32'h0));
    v.push_back(mk("lw_w1",   1, 0, 3'b010, 31, 1, 32'h0000_0400, 32'h0,        32'hDEAD_BEEF, 1, 3, 0, 1, 0, 1, 32'hDEAD_BEEF, 4'h0,    32'h0));
    v.push_back(mk("sh",      0, 1, 3'b001, 0,  0, 32'h0000_0502, 32'h1234_CAFE, 32'h0,        0, 2, 0, 0, 1, 0, 32'h0,        4'b1100, 32'hCAFE_CAFE));
    v.push_back(mk("sw",      0, 1, 3'b010, 0,  0, 32'h0000_0600, 32'h89AB_CDEF, 32'h0,        2, 4, 0, 0, 1, 0, 32'h0,        4'b1111, 32'h89AB_CDEF));
    v.push_back(mk("sh_mis",  0, 1, 3'b001, 0,  0, 32'h0000_0503, 32'h0000_1111, 32'h0,        0, 0, 1, 0, 0, 0, 32'h0,        4'h0,    32'h0));
    v.push_back(mk("f3_011",  1, 0, 3'b011, 3,  1, 32'h0000_0700, 32'h0,        32'h0,        0, 0, 1, 0, 0, 0, 32'h0,        4'h0,    32'h0));
    v.push_back(mk("lb_pos",  1, 0, 3'b000, 4,  1, 32'h0000_0100, 32'h0,        32'h1234_567F, 0, 2, 0, 1, 0, 1, 32'h0000_007F, 4'h0,    32'h0));
    v.push_back(mk("rw_both", 1, 1, 3'b000, 6,  1, 32'h0000_0000, 32'h0000_0055, 32'h0,        0, 2, 0, 0, 1, 0, 32'h0,        4'b0001, 32'h5555_5555));
    v.push_back(mk("alu_norw",0, 0, 3'b000, 9,  0, 32'h0000_5555, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h0000_5555, 4'h0,    32'h0));

    reset      = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0BAD_F00D;
    drive(nop);
    repeat (2) @(posedge clk);
    #1;
    chk("reset dmem_req",    {31'd0, dmem_req}, 32'd0);
    chk("reset dmem_we",     {31'd0, dmem_we}, 32'd0);
    chk("reset dmem_addr",   dmem_addr, 32'd0);
    chk("reset dmem_be",     {28'd0, dmem_be}, 32'd0);
    chk("reset dmem_wdata",  dmem_wdata, 32'd0);
    chk("reset ResultW",     ResultW, 32'd0);
    chk("reset ADDRTargetW", ADDRTargetW, 32'd0);
    chk("reset RdW",         {27'd0, RdW}, 32'd0);
    chk("reset RegWriteW",   {31'd0, RegWriteW}, 32'd0);
    chk("reset MisalignM",   {31'd0, MisalignM}, 32'd0);
    chk("reset StallM",      {31'd0, StallM}, 32'd0);
    reset = 1'b1;

    foreach (v[i]) run_vec(v[i]);

    // reset while a load is waiting, then a late ready must be ignored
    @(posedge clk);
    drive(mk("lw_rst", 1, 0, 3'b010, 7, 1, 32'h0000_0800, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0));
    #1;
    chk("rst_busy stall in IDLE", {31'd0, StallM}, 32'd1);
    @(posedge clk);
    #1;
    chk("rst_busy dmem_req", {31'd0, dmem_req}, 32'd1);
    @(posedge clk);
    reset = 1'b0;
    drive(nop);
    #1;
    chk("rst_busy stall held", {31'd0, StallM}, 32'd1);
    @(posedge clk);
    #1;
    chk("rst_busy dmem_req cleared", {31'd0, dmem_req}, 32'd0);
    chk("rst_busy StallM", {31'd0, StallM}, 32'd0);
    chk("rst_busy ResultW", ResultW, 32'd0);
    chk("rst_busy RdW", {27'd0, RdW}, 32'd0);
    chk("rst_busy RegWriteW", {31'd0, RegWriteW}, 32'd0);
    chk("rst_busy dmem_addr", dmem_addr, 32'd0);
    reset      = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = 32'h7777_7777;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("late ready RegWriteW", {31'd0, RegWriteW}, 32'd0);
      chk("late ready ResultW", ResultW, 32'd0);
      chk("late ready StallM", {31'd0, StallM}, 32'd0);
    end
    dmem_ready = 1'b0;

    run_vec(v[0]);
    run_vec(v[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
